// File: rtl/wb_debug_pkg.sv
// Shared widths, command opcodes and FSM state encoding for the Wishbone debug master.
package wb_debug_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned SEL_W  = 4;
    localparam int unsigned CNT_W  = 2;

    localparam logic [BYTE_W-1:0] CMD_WRITE = 8'h01;
    localparam logic [BYTE_W-1:0] CMD_READ  = 8'h02;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADDR  = 3'd1,
        WDATA = 3'd2,
        BUS   = 3'd3,
        RESP  = 3'd4
    } state_t;

endpackage

// File: rtl/wb_debug_master.sv
// Byte-stream driven Wishbone classic master: parses peek/poke frames, runs one
// bus cycle per frame and streams back a status byte or the read word.
module wb_debug_master
    import wb_debug_pkg::*;
#(
    parameter int unsigned       TIMEOUT  = 1024,
    parameter logic [BYTE_W-1:0] ACK_BYTE = 8'hA5,
    parameter logic [BYTE_W-1:0] ERR_BYTE = 8'hEE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BYTE_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic [BYTE_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [WORD_W-1:0] wb_adr_o,
    output logic [WORD_W-1:0] wb_dat_o,
    input  logic [WORD_W-1:0] wb_dat_i,
    output logic [SEL_W-1:0]  wb_sel_o,
    output logic              wb_we_o,
    output logic              wb_cyc_o,
    output logic              wb_stb_o,
    input  logic              wb_ack_i,
    output logic              busy
);

    localparam int unsigned      TMO_W    = $clog2(TIMEOUT);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(3);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_d;
    logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
    logic [WORD_W-1:0] rdata_q, rdata_d;
    logic [WORD_W-1:0] adr_d, dat_d;
    logic [BYTE_W-1:0] tx_data_d;
    logic [SEL_W-1:0]  sel_d;
    logic              we_d, cyc_d, tx_valid_d, busy_d;

    logic              is_cmd, last_rx, tx_accept, tmo_hit;

    // Frame and handshake qualifiers shared by next-state and datapath logic
    always_comb begin
        is_cmd    = (rx_data == CMD_WRITE) || (rx_data == CMD_READ);
        last_rx   = rx_valid && (byte_cnt_q == CNT_LAST);
        tx_accept = tx_valid && tx_ready;
        tmo_hit   = (tmo_cnt_q == TMO_LAST);
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (rx_valid) begin
                    state_d = is_cmd ? ADDR : RESP;
                end
            end
            ADDR: begin
                if (last_rx) begin
                    state_d = wb_we_o ? WDATA : BUS;
                end
            end
            WDATA: begin
                if (last_rx) begin
                    state_d = BUS;
                end
            end
            BUS: begin
                if (wb_ack_i || tmo_hit) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (tx_accept && (byte_cnt_q == '0)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output and datapath next values; bus/tx strobes decode the upcoming state
    always_comb begin
        adr_d      = wb_adr_o;
        dat_d      = wb_dat_o;
        we_d       = wb_we_o;
        tx_data_d  = tx_data;
        rdata_d    = rdata_q;
        byte_cnt_d = byte_cnt_q;
        tmo_cnt_d  = tmo_cnt_q;
        cyc_d      = (state_d == BUS);
        sel_d      = cyc_d ? {SEL_W{1'b1}} : '0;
        tx_valid_d = (state_d == RESP);
        busy_d     = (state_d != IDLE);

        case (state_q)
            IDLE: begin
                if (rx_valid) begin
                    byte_cnt_d = '0;
                    if (is_cmd) begin
                        we_d = (rx_data == CMD_WRITE);
                    end else begin
                        tx_data_d = ERR_BYTE;
                    end
                end
            end
            ADDR: begin
                if (rx_valid) begin
                    adr_d      = {wb_adr_o[WORD_W-BYTE_W-1:0], rx_data};
                    byte_cnt_d = byte_cnt_q + CNT_W'(1);
                end
            end
            WDATA: begin
                if (rx_valid) begin
                    dat_d      = {wb_dat_o[WORD_W-BYTE_W-1:0], rx_data};
                    byte_cnt_d = byte_cnt_q + CNT_W'(1);
                end
            end
            BUS: begin
                tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                if (wb_ack_i) begin
                    tmo_cnt_d = '0;
                    if (wb_we_o) begin
                        tx_data_d  = ACK_BYTE;
                        byte_cnt_d = '0;
                    end else begin
                        tx_data_d  = wb_dat_i[WORD_W-1 -: BYTE_W];
                        rdata_d    = {wb_dat_i[WORD_W-BYTE_W-1:0], BYTE_W'(0)};
                        byte_cnt_d = CNT_LAST;
                    end
                end else if (tmo_hit) begin
                    tmo_cnt_d  = '0;
                    tx_data_d  = ERR_BYTE;
                    byte_cnt_d = '0;
                end
            end
            RESP: begin
                if (tx_accept && (byte_cnt_q != '0)) begin
                    tx_data_d  = rdata_q[WORD_W-1 -: BYTE_W];
                    rdata_d    = {rdata_q[WORD_W-BYTE_W-1:0], BYTE_W'(0)};
                    byte_cnt_d = byte_cnt_q - CNT_W'(1);
                end
            end
            default: begin
                byte_cnt_d = '0;
                tmo_cnt_d  = '0;
            end
        endcase
    end

    // Registered outputs and datapath
    always_ff @(posedge clk) begin
        if (!rst) begin
            wb_adr_o   <= '0;
            wb_dat_o   <= '0;
            wb_we_o    <= 1'b0;
            wb_sel_o   <= '0;
            wb_cyc_o   <= 1'b0;
            wb_stb_o   <= 1'b0;
            tx_data    <= '0;
            tx_valid   <= 1'b0;
            busy       <= 1'b0;
            rdata_q    <= '0;
            byte_cnt_q <= '0;
            tmo_cnt_q  <= '0;
        end else begin
            wb_adr_o   <= adr_d;
            wb_dat_o   <= dat_d;
            wb_we_o    <= we_d;
            wb_sel_o   <= sel_d;
            wb_cyc_o   <= cyc_d;
            wb_stb_o   <= cyc_d;
            tx_data    <= tx_data_d;
            tx_valid   <= tx_valid_d;
            busy       <= busy_d;
            rdata_q    <= rdata_d;
            byte_cnt_q <= byte_cnt_d;
            tmo_cnt_q  <= tmo_cnt_d;
        end
    end

endmodule

// File: tb/tb_wb_debug_master.sv
// Bench for wb_debug_master: frame-level stimulus, a wait-state slave and a word-array model.
module tb_wb_debug_master;

    localparam int unsigned TMO = 16;
    localparam logic [7:0]  ACK = 8'hA5;
    localparam logic [7:0]  ERR = 8'hEE;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [31:0] wb_adr_o, wb_dat_o, wb_dat_i;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o, wb_cyc_o, wb_stb_o, wb_ack_i;
    logic        busy;

    wb_debug_master #(.TIMEOUT(TMO), .ACK_BYTE(ACK), .ERR_BYTE(ERR)) dut (
        .clk(clk), .rst(rst),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
        .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o),
        .wb_stb_o(wb_stb_o), .wb_ack_i(wb_ack_i), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Slave: 16-word memory on adr[5:2], programmable wait states or never acks
    int          slave_waits;
    bit          slave_dead;
    bit          slave_init;
    int          wait_cnt;
    logic [31:0] slave_mem [16];
    logic [31:0] model_mem [16];

    function automatic logic [31:0] init_word(input int i);
        return (i == 2) ? 32'h12345678 : ({4{8'(i)}} ^ 32'hC0DE0000);
    endfunction

    assign wb_ack_i = wb_cyc_o && wb_stb_o && !slave_dead && (wait_cnt == slave_waits);
    assign wb_dat_i = wb_ack_i ? slave_mem[wb_adr_o[5:2]] : 32'hBAD0BAD0;

    always @(posedge clk) begin
        if (!(wb_cyc_o && wb_stb_o) || wb_ack_i) wait_cnt <= 0;
        else                                     wait_cnt <= wait_cnt + 1;
        if (slave_init) begin
            for (int i = 0; i < 16; i++) slave_mem[i] <= init_word(i);
        end else if (wb_ack_i && wb_we_o) begin
            slave_mem[wb_adr_o[5:2]] <= wb_dat_o;
        end
    end

    // Bus monitor: counts cycles, records the last one, flags unstable or malformed strobes
    logic        cyc_prev = 1'b0;
    int          bus_starts = 0;
    int          cyc_len = 0;
    logic [31:0] mon_adr, mon_dat;
    logic        mon_we;
    bit          bus_bad = 1'b0;

    always @(negedge clk) begin
        if (wb_cyc_o) begin
            if (!cyc_prev) begin
                bus_starts <= bus_starts + 1;
                cyc_len    <= 1;
                mon_adr    <= wb_adr_o;
                mon_dat    <= wb_dat_o;
                mon_we     <= wb_we_o;
            end else begin
                cyc_len <= cyc_len + 1;
                if (wb_adr_o !== mon_adr || wb_dat_o !== mon_dat || wb_we_o !== mon_we)
                    bus_bad <= 1'b1;
            end
            if (wb_stb_o !== 1'b1 || wb_sel_o !== 4'hF) bus_bad <= 1'b1;
        end else if (wb_stb_o !== 1'b0) begin
            bus_bad <= 1'b1;
        end
        cyc_prev <= wb_cyc_o;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Caller sits at a negedge; each call strobes one byte for one cycle
    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    logic [7:0] resp_q[$];

    // Collect n tx bytes; mode 0 ready high, 1 random ready, 2 ten-cycle stall between bytes
    task automatic collect(input int n, input int mode, input bit junk, input string tag);
        int         budget = 2000;
        int         hold   = 0;
        bit         pend   = 1'b0;
        logic [7:0] pdata  = '0;
        resp_q.delete();
        while (resp_q.size() < n && budget > 0) begin
            @(negedge clk);
            budget--;
            if (pend) begin
                chk({tag, "_hold_valid"}, 64'(tx_valid), 64'(1));
                chk({tag, "_hold_data"}, 64'(tx_data), 64'(pdata));
            end
            case (mode)
                0:       tx_ready = 1'b1;
                1:       tx_ready = 1'($urandom_range(0, 1));
                default: tx_ready = (hold == 0);
            endcase
            if (junk && tx_valid) begin
                rx_valid = 1'($urandom_range(0, 1));
                rx_data  = 8'($urandom);
            end else begin
                rx_valid = 1'b0;
            end
            if (tx_valid && tx_ready) begin
                resp_q.push_back(tx_data);
                hold = 10;
                pend = 1'b0;
            end else begin
                if (hold > 0) hold--;
                pend  = tx_valid;
                pdata = tx_data;
            end
        end
        @(negedge clk);
        rx_valid = 1'b0;
        tx_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk({tag, "_tx_idle"}, 64'(tx_valid), 64'(0));
        chk({tag, "_busy_idle"}, 64'(busy), 64'(0));
    endtask

    // One complete frame, checked against the word-array model and timeout rule
    task automatic transact(input bit is_wr, input logic [31:0] a, input logic [31:0] d,
                            input int waits, input bit dead, input int mode, input bit junk,
                            input string tag);
        int         starts0;
        bit         ok;
        int         exp_len;
        logic [7:0] exp_b [4];
        logic [31:0] w;
        slave_waits = waits;
        slave_dead  = dead;
        starts0     = bus_starts;
        ok          = !dead && (waits < int'(TMO));
        w           = model_mem[a[5:2]];
        send_byte(is_wr ? wb_debug_pkg::CMD_WRITE : wb_debug_pkg::CMD_READ);
        for (int i = 3; i >= 0; i--) send_byte(a[8*i +: 8]);
        if (is_wr) for (int i = 3; i >= 0; i--) send_byte(d[8*i +: 8]);
        exp_len = (ok && !is_wr) ? 4 : 1;
        if (exp_len == 4) begin
            for (int i = 0; i < 4; i++) exp_b[i] = w[31-8*i -: 8];
        end else begin
            exp_b[0] = ok ? ACK : ERR;
        end
        collect(exp_len, mode, junk, tag);
        chk({tag, "_resp_len"}, 64'(resp_q.size()), 64'(exp_len));
        for (int i = 0; i < exp_len; i++)
            chk({tag, "_resp_byte"}, (i < resp_q.size()) ? 64'(resp_q[i]) : 64'hFFFF, 64'(exp_b[i]));
        chk({tag, "_bus_count"}, 64'(bus_starts - starts0), 64'(1));
        chk({tag, "_cyc_len"}, 64'(cyc_len), ok ? 64'(waits + 1) : 64'(TMO));
        chk({tag, "_adr"}, 64'(mon_adr), 64'(a));
        chk({tag, "_we"}, 64'(mon_we), 64'(is_wr));
        if (is_wr) chk({tag, "_dat"}, 64'(mon_dat), 64'(d));
        chk({tag, "_bus_shape"}, 64'(bus_bad), 64'(0));
        if (ok && is_wr) model_mem[a[5:2]] = d;
    endtask

    task automatic bad_cmd(input logic [7:0] b, input string tag);
        int starts0 = bus_starts;
        send_byte(b);
        collect(1, 0, 1'b0, tag);
        chk({tag, "_resp_len"}, 64'(resp_q.size()), 64'(1));
        chk({tag, "_resp_byte"}, (resp_q.size() > 0) ? 64'(resp_q[0]) : 64'hFFFF, 64'(ERR));
        chk({tag, "_no_bus"}, 64'(bus_starts - starts0), 64'(0));
    endtask

    initial begin
        int          guard;
        int          starts0;
        logic [7:0]  b;
        logic [31:0] a, d;

        rst = 1'b0; rx_valid = 1'b0; rx_data = '0; tx_ready = 1'b0;
        slave_waits = 0; slave_dead = 1'b0; slave_init = 1'b1;
        for (int i = 0; i < 16; i++) model_mem[i] = init_word(i);
        repeat (3) @(negedge clk);
        chk("rst_cyc", 64'(wb_cyc_o), 64'(0));
        chk("rst_stb", 64'(wb_stb_o), 64'(0));
        chk("rst_we", 64'(wb_we_o), 64'(0));
        chk("rst_tx_valid", 64'(tx_valid), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_adr", 64'(wb_adr_o), 64'(0));
        chk("rst_dat", 64'(wb_dat_o), 64'(0));
        chk("rst_sel", 64'(wb_sel_o), 64'(0));
        chk("rst_tx_data", 64'(tx_data), 64'(0));
        slave_init = 1'b0;
        rst = 1'b1;
        @(negedge clk);

        transact(1'b1, 32'h20000004, 32'hDEADBEEF, 2, 1'b0, 0, 1'b0, "write");
        transact(1'b0, 32'h50000008, 32'h0, 0, 1'b0, 0, 1'b0, "read");
        transact(1'b0, 32'h60000010, 32'h0, 0, 1'b1, 0, 1'b0, "timeout");
        transact(1'b0, 32'h20000004, 32'h0, 1, 1'b0, 0, 1'b0, "after_timeout");
        transact(1'b0, 32'h50000008, 32'h0, TMO - 1, 1'b0, 0, 1'b0, "ack_last_cycle");
        bad_cmd(8'h7F, "badcmd");
        transact(1'b0, 32'h20000004, 32'h0, 0, 1'b0, 0, 1'b0, "after_badcmd");
        transact(1'b0, 32'h5000000B, 32'h0, 3, 1'b0, 2, 1'b1, "backpressure");
        transact(1'b0, 32'h20000004, 32'h0, 0, 1'b0, 0, 1'b0, "after_junk");

        // Reset three cycles into a stalled bus cycle
        slave_dead = 1'b1;
        send_byte(wb_debug_pkg::CMD_READ);
        for (int i = 3; i >= 0; i--) send_byte(8'h30 + 8'(i));
        guard = 0;
        while (!wb_cyc_o && guard < 10) begin
            @(negedge clk);
            guard++;
        end
        chk("midrst_cyc_started", 64'(wb_cyc_o), 64'(1));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_cyc", 64'(wb_cyc_o), 64'(0));
        chk("midrst_stb", 64'(wb_stb_o), 64'(0));
        chk("midrst_tx_valid", 64'(tx_valid), 64'(0));
        chk("midrst_busy", 64'(busy), 64'(0));
        rst = 1'b1;
        starts0 = bus_starts;
        tx_ready = 1'b1;
        repeat (TMO + 4) @(negedge clk);
        chk("midrst_no_resp", 64'(tx_valid), 64'(0));
        chk("midrst_no_bus", 64'(bus_starts - starts0), 64'(0));
        tx_ready = 1'b0;
        slave_dead = 1'b0;
        transact(1'b1, 32'h4000003C, 32'hCAFEF00D, 1, 1'b0, 0, 1'b0, "post_rst_write");
        transact(1'b0, 32'h4000003C, 32'h0, 0, 1'b0, 1, 1'b0, "post_rst_read");

        // Randomized frames against the word-array model
        for (int k = 0; k < 14; k++) begin
            a = $urandom;
            d = $urandom;
            case ($urandom_range(0, 7))
                0: begin
                    b = 8'($urandom_range(3, 255));
                    bad_cmd(b, "rnd_bad");
                end
                1: transact(1'($urandom_range(0, 1)), a, d, 0, 1'b1,
                            int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), "rnd_dead");
                default: transact(1'($urandom_range(0, 1)), a, d, int'($urandom_range(0, 5)), 1'b0,
                                  int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), "rnd");
            endcase
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_debug_master.md
# wb_debug_master

Wishbone bus master driven by a byte stream, so a host can peek and poke the SoC address space without the LM32. The master sits between the UART byte receiver/transmitter and one of the spare conbus master ports (m2..m6). It turns framed command bytes into single Wishbone classic read or write cycles. It returns a status byte or read data over the outgoing byte stream.

## Interface
Parameters:
- TIMEOUT, 1024: cycles to wait for wb_ack_i before aborting; legal range 2..65535.
- ACK_BYTE, 8'hA5: status byte sent after a successful write.
- ERR_BYTE, 8'hEE: status byte sent on a bad command or a bus timeout.

Ports:
- clk  in  1  system clock; one clock domain, all logic on its rising edge.
- rst  in  1  synchronous, active-low reset.
- rx_data  in  8  received byte.
- rx_valid  in  1  one-cycle strobe, one per received byte; no backpressure.
- tx_data  out  8  byte to transmit.
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  transmitter accepts the byte when tx_valid && tx_ready.
- wb_adr_o  out  32  bus address.
- wb_dat_o  out  32  write data.
- wb_dat_i  in  32  read data.
- wb_sel_o  out  4  byte select; always 4'hF while wb_cyc_o is high.
- wb_we_o  out  1  1 = write.
- wb_cyc_o  out  1  cycle.
- wb_stb_o  out  1  strobe.
- wb_ack_i  in  1  slave acknowledge.
- busy  out  1  high whenever the state is not IDLE.

## Operation
Frame format (all multi-byte fields MSB first):
- Write: 8'h01, 4 address bytes, 4 data bytes. Reply is ACK_BYTE.
- Read: 8'h02, 4 address bytes. Reply is 4 data bytes.
- Any other first byte: reply ERR_BYTE. The FSM then returns to IDLE.
- Address is used as-is. It is not word-aligned by the block; the slaves ignore adr[1:0].

FSM states: IDLE, ADDR, WDATA, BUS, RESP.
- IDLE, on rx_valid:
  - 01 or 02: latch we, clear the byte counter, go to ADDR.
  - any other value: load ERR_BYTE, go to RESP.
- ADDR: each rx_valid shifts a byte into adr. After the 4th byte:
  - write: go to WDATA.
  - read: go to BUS.
- WDATA: each rx_valid shifts a byte into dat_o. After the 4th byte, go to BUS.
- BUS: cyc, stb and sel=F are asserted. The timeout counter increments every cycle.
  - On ack: capture wb_dat_i (read), drop cyc/stb, load the response, go to RESP.
  - When the counter reaches TIMEOUT-1 without ack: drop cyc/stb, load ERR_BYTE, go to RESP.
- RESP: present response bytes on tx_data with tx_valid high. Advance one byte per accepted handshake. After the last byte is accepted, return to IDLE.
  - Response length: 1 byte (ack or error) or 4 bytes (read data).

Input handling:
- rx_valid in BUS or RESP is ignored; the byte is dropped.
- No inter-byte timeout. A partial frame waits indefinitely; only reset clears it.

## Timing
- Reset values: wb_cyc_o, wb_stb_o, wb_we_o, tx_valid and busy are 0. wb_adr_o, wb_dat_o, wb_sel_o and tx_data are 0. The state is IDLE and all counters are 0.
- Bus start: wb_cyc_o/wb_stb_o rise on the edge after the cycle in which the last frame byte was strobed.
- Bus end: cyc/stb fall on the same edge that samples wb_ack_i=1, so the master never holds stb for a second cycle after ack.
- Bus latency: with a zero-wait slave (ack in the first stb cycle), cyc is high for exactly 1 cycle.
- Response start: tx_valid rises on the edge after the bus phase ends.
- Response hold: tx_valid and tx_data are held stable until accepted.
- Back-to-back bytes: the next byte is presented the cycle after acceptance, giving 1 byte/cycle when tx_ready is stuck high.
- Timeout: cyc is high for exactly TIMEOUT cycles. An ack arriving in that final cycle wins, and the transfer counts as a success.
- wb_adr_o, wb_dat_o and wb_we_o are stable for the whole cycle. They are only updated outside BUS.
- Reset low at any edge, including mid-bus: cyc/stb are low after that edge and any pending response is discarded.

## Structure
- Package wb_debug_pkg holds:
  - command constants CMD_WRITE=8'h01 and CMD_READ=8'h02;
  - the state enum.
- ACK_BYTE and ERR_BYTE stay as module parameters.
- No sub-module is needed. The serializer and deserializer are a 32-bit shift register plus a 2-bit byte counter, kept inline. The timeout counter is $clog2(TIMEOUT) bits.

## Test plan
- Write: send 01 20 00 00 04 DE AD BE EF; the slave acks after 2 wait states.
  - Expected: one cycle with adr=32'h20000004, dat_o=32'hDEADBEEF, we=1, sel=F.
  - Expected: tx emits A5 once.
- Read: send 02 50 00 00 08; the slave returns 32'h12345678 with zero wait.
  - Expected: cyc high 1 cycle.
  - Expected: tx emits 12 34 56 78 in order.
- Timeout: read an address whose slave never acks, with TIMEOUT=16.
  - Expected: cyc high exactly 16 cycles, then tx emits EE.
  - Expected: a following valid read succeeds.
- Bad command: send 7F.
  - Expected: tx emits EE with no bus activity.
  - Expected: the next frame parses normally.
- Backpressure: during a read response, hold tx_ready low for 10 cycles between bytes.
  - Expected: tx_data stays stable and no byte is lost or duplicated.
  - Expected: rx bytes strobed in RESP are ignored.
- Reset mid-bus: pull rst low 3 cycles into a stalled cycle.
  - Expected: cyc/stb/tx_valid are low after that edge and busy=0.
  - Expected: a fresh write completes correctly.
